// File: rtl/nf_cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : nf_cpu_pkg                                                 |
// | Shared CPU encodings: access sizes, LSU sequencer states and the     |
// | alignment rule used by the load/store path.                          |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package nf_cpu_pkg;

  // Access size encodings carried by the decoded memory-stage control
  localparam logic [1:0] NF_SZ_B = 2'b00;
  localparam logic [1:0] NF_SZ_H = 2'b01;
  localparam logic [1:0] NF_SZ_W = 2'b10;

  // Load/store sequencer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2
  } lsu_state_t;

  // An access is illegal when its size is reserved or its address is not
  // a multiple of the access width.
  function automatic logic nf_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    case (size)
      NF_SZ_B: return 1'b0;
      NF_SZ_H: return addr_lo[0];
      NF_SZ_W: return (addr_lo != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/nf_lsu_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : nf_lsu_align                                               |
// | Combinational lane logic for the LSU: misalignment detection, byte   |
// | enables, store-data lane replication, load extraction/extension.     |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module nf_lsu_align
  import nf_cpu_pkg::*;
(
  input  logic [1:0]  i_chk_size,  // size of the request being offered
  input  logic [1:0]  i_chk_addr,  // low address bits of the offered request
  input  logic [1:0]  i_size,      // size of the latched transaction
  input  logic        i_sign,      // sign-extend the loaded value
  input  logic [1:0]  i_addr_lo,   // low address bits of the latched transaction
  input  logic [31:0] i_st_data,
  input  logic [31:0] i_ld_raw,
  output logic        o_misalign,
  output logic [3:0]  o_be,
  output logic [31:0] o_st_lanes,
  output logic [31:0] o_ld_ext
);

  logic [31:0] w_ld_shift;

  assign o_misalign = nf_misaligned(i_chk_size, i_chk_addr);

  // Bring the addressed byte lane down to bit 0 before extension
  assign w_ld_shift = i_ld_raw >> {i_addr_lo, 3'b000};

  // Per-size byte enables, store replication and load extension
  always_comb begin
    o_be       = 4'b1111;
    o_st_lanes = i_st_data;
    o_ld_ext   = w_ld_shift;
    case (i_size)
      NF_SZ_B: begin
        o_be       = 4'b0001 << i_addr_lo;
        o_st_lanes = {4{i_st_data[7:0]}};
        o_ld_ext   = {{24{i_sign & w_ld_shift[7]}}, w_ld_shift[7:0]};
      end
      NF_SZ_H: begin
        o_be       = 4'b0011 << i_addr_lo;
        o_st_lanes = {2{i_st_data[15:0]}};
        o_ld_ext   = {{16{i_sign & w_ld_shift[15]}}, w_ld_shift[15:0]};
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/nf_lsu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : nf_lsu_ctrl                                                |
// | Load/store sequencer between the memory stage and the data bus:      |
// | request/ack/read-valid handshake, pipeline stall, load writeback,    |
// | misalignment and timeout reporting.                                  |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module nf_lsu_ctrl
  import nf_cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255  // 0 disables the timeout
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_vld,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wd,
  input  logic [4:0]  req_wa,
  output logic        lsu_busy,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic        misalign,
  output logic        bus_err,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wd,
  input  logic        dm_ack,
  input  logic [31:0] dm_rd,
  input  logic        dm_rd_vld
);

  localparam bit         c_to_en    = (TIMEOUT_CYC != 0);
  localparam logic [7:0] c_cnt_last = 8'(TIMEOUT_CYC - 1);

  lsu_state_t  r_state;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_sign;
  logic [31:0] r_addr;
  logic [31:0] r_wd;
  logic [4:0]  r_wa;
  logic [7:0]  r_cnt;

  logic        w_req_mis;
  logic [3:0]  w_be;
  logic [31:0] w_st_lanes;
  logic [31:0] w_ld_ext;
  logic        w_in_req;
  logic        w_done_ok;
  logic        w_timeout;

  nf_lsu_align u_align (
    .i_chk_size (req_size),
    .i_chk_addr (req_addr[1:0]),
    .i_size     (r_size),
    .i_sign     (r_sign),
    .i_addr_lo  (r_addr[1:0]),
    .i_st_data  (r_wd),
    .i_ld_raw   (dm_rd),
    .o_misalign (w_req_mis),
    .o_be       (w_be),
    .o_st_lanes (w_st_lanes),
    .o_ld_ext   (w_ld_ext)
  );

  // Bus side is driven from latched request state only while requesting
  assign w_in_req = (r_state == REQ);
  assign dm_req   = w_in_req;
  assign dm_we    = w_in_req & r_we;
  assign dm_addr  = w_in_req ? {r_addr[31:2], 2'b00} : 32'd0;
  assign dm_be    = w_in_req ? w_be : 4'd0;
  assign dm_wd    = w_in_req ? w_st_lanes : 32'd0;

  // Completion terms; a real response takes priority over the timeout
  assign w_done_ok = ((r_state == REQ) & dm_ack & (r_we | dm_rd_vld)) |
                     ((r_state == WAIT_RD) & dm_rd_vld);
  assign w_timeout = c_to_en & (r_state != IDLE) & (r_cnt == c_cnt_last);

  // Stall: accepting in IDLE, otherwise until the completing cycle
  always_comb begin
    lsu_busy = 1'b0;
    if (r_state == IDLE) lsu_busy = req_vld & ~w_req_mis;
    else                 lsu_busy = ~(w_done_ok | w_timeout);
  end

  // Sequencer, request latches, timeout counter and registered pulses
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_we     <= 1'b0;
      r_size   <= 2'd0;
      r_sign   <= 1'b0;
      r_addr   <= 32'd0;
      r_wd     <= 32'd0;
      r_wa     <= 5'd0;
      r_cnt    <= 8'd0;
      rf_we    <= 1'b0;
      rf_wa    <= 5'd0;
      rf_wd    <= 32'd0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      rf_we    <= 1'b0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_vld) begin
            if (w_req_mis) begin
              misalign <= 1'b1;
            end else begin
              r_we    <= req_we;
              r_size  <= req_size;
              r_sign  <= req_sign;
              r_addr  <= req_addr;
              r_wd    <= req_wd;
              r_wa    <= req_wa;
              r_cnt   <= 8'd0;
              r_state <= REQ;
            end
          end
        end
        REQ, WAIT_RD: begin
          r_cnt <= r_cnt + 8'd1;
          if (w_done_ok) begin
            r_state <= IDLE;
            if (!r_we) begin
              rf_we <= (r_wa != 5'd0);
              rf_wa <= r_wa;
              rf_wd <= w_ld_ext;
            end
          end else if (w_timeout) begin
            r_state <= IDLE;
            bus_err <= 1'b1;
          end else if ((r_state == REQ) && dm_ack) begin
            r_state <= WAIT_RD;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nf_lsu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_nf_lsu_ctrl                                             |
// | Self-checking bench for nf_lsu_ctrl: directed vector table, reset    |
// | sequence and randomized transactions against a behavioural model.    |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_nf_lsu_ctrl;

  localparam int TO_CYC = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_vld, req_we, req_sign;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wd;
  logic [4:0]  req_wa;
  logic        lsu_busy, rf_we, misalign, bus_err;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        dm_req, dm_we, dm_ack, dm_rd_vld;
  logic [31:0] dm_addr, dm_wd, dm_rd;
  logic [3:0]  dm_be;

  int n_chk  = 0;
  int n_fail = 0;

  nf_lsu_ctrl #(.TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .resetn(resetn),
    .req_vld(req_vld), .req_we(req_we), .req_size(req_size), .req_sign(req_sign),
    .req_addr(req_addr), .req_wd(req_wd), .req_wa(req_wa),
    .lsu_busy(lsu_busy), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .misalign(misalign), .bus_err(bus_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wd(dm_wd),
    .dm_ack(dm_ack), .dm_rd(dm_rd), .dm_rd_vld(dm_rd_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [4:0]  wa;
    int          a;      // REQ cycles before dm_ack
    int          r;      // cycles from dm_ack to dm_rd_vld (loads)
    logic [31:0] rd;
    logic        exp_mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    int          exp_busy;
    logic        exp_rfwe;
    logic [31:0] exp_rfwd;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic sg,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [4:0] wa, input int a, input int r,
                              input logic [31:0] rd, input logic mis, input logic [3:0] be,
                              input logic [31:0] ewd, input int busy, input logic rfwe,
                              input logic [31:0] rfwd, input logic err);
    vec_t v;
    v.we = we; v.sz = sz; v.sg = sg; v.addr = addr; v.wd = wd; v.wa = wa;
    v.a = a; v.r = r; v.rd = rd;
    v.exp_mis = mis; v.exp_be = be; v.exp_wd = ewd; v.exp_busy = busy;
    v.exp_rfwe = rfwe; v.exp_rfwd = rfwd; v.exp_err = err;
    return v;
  endfunction

  // Reference: access width in bytes drives alignment, lanes and extension;
  // completion index vs. the timeout budget drives latency and errors.
  function automatic vec_t model(input vec_t vin);
    vec_t v;
    int n, done_idx;
    logic [31:0] val, mask;
    v = vin;
    v.exp_be = 4'd0; v.exp_wd = 32'd0; v.exp_rfwd = 32'd0;
    v.exp_mis = (v.sz == 2'd3);
    if (v.sz != 2'd3) begin
      n = 1 << v.sz;
      v.exp_mis = (v.addr % n) != 0;
      v.exp_be  = 4'(((1 << n) - 1) << v.addr[1:0]);
      for (int b = 0; b < 4; b++) v.exp_wd[8*b +: 8] = v.wd[8*(b % n) +: 8];
      val  = v.rd >> (8 * v.addr[1:0]);
      mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*n)) - 32'd1);
      val  = val & mask;
      if (v.sg && val[8*n-1]) val = val | ~mask;
      v.exp_rfwd = val;
    end
    done_idx   = v.we ? v.a : v.a + v.r;
    v.exp_err  = done_idx > TO_CYC - 1;
    v.exp_busy = v.exp_err ? TO_CYC : done_idx + 1;
    v.exp_rfwe = !v.we && !v.exp_err && (v.wa != 5'd0);
    return v;
  endfunction

  // Offer one request, play the bus side, then check writeback/error pulses
  task automatic txn(input vec_t v);
    int  k, busy_n;
    bit  fin;
    @(posedge clk); #1;
    req_vld = 1'b1; req_we = v.we; req_size = v.sz; req_sign = v.sg;
    req_addr = v.addr; req_wd = v.wd; req_wa = v.wa;
    dm_ack = 1'b0; dm_rd_vld = 1'b0;
    @(negedge clk);
    chk("busy_accept", lsu_busy, !v.exp_mis);
    chk("dm_req_idle", dm_req, 1'b0);
    if (v.exp_mis) begin
      @(posedge clk); #1 req_vld = 1'b0;
      @(negedge clk);
      chk("misalign_pulse", misalign, 1'b1);
      chk("misalign_no_req", dm_req, 1'b0);
      chk("misalign_busy", lsu_busy, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("misalign_clear", misalign, 1'b0);
      chk("misalign_no_req2", dm_req, 1'b0);
    end else begin
      k = 0; busy_n = 1; fin = 1'b0;
      while (!fin && k < 40) begin
        @(posedge clk); #1;
        dm_ack    = (k == v.a);
        dm_rd_vld = !v.we && (k == v.a + v.r);
        dm_rd     = dm_rd_vld ? v.rd : $urandom;
        @(negedge clk);
        chk("dm_req", dm_req, k <= v.a);
        if (k <= v.a) begin
          chk("dm_addr", dm_addr, {v.addr[31:2], 2'b00});
          chk("dm_we", dm_we, v.we);
          chk("dm_be", dm_be, v.exp_be);
          if (v.we) chk("dm_wd", dm_wd, v.exp_wd);
        end
        if (lsu_busy) busy_n++;
        else fin = 1'b1;
        k++;
      end
      chk("completed", fin, 1'b1);
      chk("busy_cycles", busy_n, v.exp_busy);
      @(posedge clk); #1;
      req_vld = 1'b0; dm_ack = 1'b0; dm_rd_vld = 1'b0;
      @(negedge clk);
      chk("rf_we", rf_we, v.exp_rfwe);
      chk("bus_err", bus_err, v.exp_err);
      chk("idle_busy", lsu_busy, 1'b0);
      if (v.exp_rfwe) begin
        chk("rf_wd", rf_wd, v.exp_rfwd);
        chk("rf_wa", rf_wa, v.wa);
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk("rf_we_pulse", rf_we, 1'b0);
      chk("bus_err_pulse", bus_err, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[15];
    vec_t v;

    resetn = 1'b0; req_vld = 1'b0; req_we = 1'b0; req_size = 2'd0; req_sign = 1'b0;
    req_addr = 32'd0; req_wd = 32'd0; req_wa = 5'd0;
    dm_ack = 1'b0; dm_rd = 32'd0; dm_rd_vld = 1'b0;

    //           we sz sg addr          wd            wa  a   r  rd            mis be     exp_wd        busy rfwe rfwd          err
    tbl[0]  = mk(1, 2, 0, 32'h0000_0104, 32'hDEAD_BEEF, 0, 2,  0, 32'h0,        0, 4'hF, 32'hDEAD_BEEF, 3, 0, 32'h0,         0);
    tbl[1]  = mk(0, 0, 1, 32'h0000_0103, 32'h0,         5, 0,  0, 32'h8011_2233,0, 4'h8, 32'h0,         1, 1, 32'hFFFF_FF80, 0);
    tbl[2]  = mk(0, 0, 0, 32'h0000_0103, 32'h0,         5, 0,  0, 32'h8011_2233,0, 4'h8, 32'h0,         1, 1, 32'h0000_0080, 0);
    tbl[3]  = mk(1, 1, 0, 32'h0000_0102, 32'h0000_A5A5, 0, 0,  0, 32'h0,        0, 4'hC, 32'hA5A5_A5A5, 1, 0, 32'h0,         0);
    tbl[4]  = mk(0, 1, 1, 32'h0000_0101, 32'h0,         6, 0,  0, 32'h0,        1, 4'h0, 32'h0,         0, 0, 32'h0,         0);
    tbl[5]  = mk(0, 2, 0, 32'h0000_0200, 32'h0,         7, 0,  3, 32'h1234_5678,0, 4'hF, 32'h0,         4, 1, 32'h1234_5678, 0);
    tbl[6]  = mk(0, 2, 0, 32'h0000_0200, 32'h0,         0, 0,  3, 32'h1234_5678,0, 4'hF, 32'h0,         4, 0, 32'h1234_5678, 0);
    tbl[7]  = mk(1, 2, 0, 32'h0000_0300, 32'h1111_2222, 0, 10, 0, 32'h0,        0, 4'hF, 32'h1111_2222, 4, 0, 32'h0,         1);
    tbl[8]  = mk(1, 2, 0, 32'h0000_0300, 32'h3333_4444, 0, 3,  0, 32'h0,        0, 4'hF, 32'h3333_4444, 4, 0, 32'h0,         0);
    tbl[9]  = mk(0, 2, 0, 32'h0000_0204, 32'h0,         3, 0,  4, 32'hCAFE_0001,0, 4'hF, 32'h0,         4, 0, 32'h0,         1);
    tbl[10] = mk(0, 1, 1, 32'h0000_0202, 32'h0,         9, 1,  1, 32'h8001_5555,0, 4'hC, 32'h0,         3, 1, 32'hFFFF_8001, 0);
    tbl[11] = mk(1, 0, 0, 32'h0000_0101, 32'h1234_567E, 0, 0,  0, 32'h0,        0, 4'h2, 32'h7E7E_7E7E, 1, 0, 32'h0,         0);
    tbl[12] = mk(1, 3, 0, 32'h0000_0400, 32'h0,         0, 0,  0, 32'h0,        1, 4'h0, 32'h0,         0, 0, 32'h0,         0);
    tbl[13] = mk(0, 2, 0, 32'h0000_0402, 32'h0,         2, 0,  0, 32'h0,        1, 4'h0, 32'h0,         0, 0, 32'h0,         0);
    tbl[14] = mk(0, 1, 0, 32'h0000_0200, 32'h0,        31, 0,  0, 32'hABCD_F00D,0, 4'h3, 32'h0,         1, 1, 32'h0000_F00D, 0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", lsu_busy, 1'b0);
    chk("rst_dm_req", dm_req, 1'b0);
    chk("rst_dm_be", dm_be, 4'd0);
    chk("rst_dm_addr", dm_addr, 32'd0);
    chk("rst_dm_wd", dm_wd, 32'd0);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_rf_wd", rf_wd, 32'd0);
    chk("rst_misalign", misalign, 1'b0);
    chk("rst_bus_err", bus_err, 1'b0);
    @(posedge clk); #1 resetn = 1'b1;

    // Directed vectors
    for (int i = 0; i < 15; i++) txn(tbl[i]);

    // Reset while waiting for read data
    @(posedge clk); #1;
    req_vld = 1'b1; req_we = 1'b0; req_size = 2'd2; req_sign = 1'b0;
    req_addr = 32'h0000_0500; req_wa = 5'd4;
    @(negedge clk);
    @(posedge clk); #1 dm_ack = 1'b1;
    @(negedge clk);
    chk("rst_seq_req", dm_req, 1'b1);
    @(posedge clk); #1 dm_ack = 1'b0;
    @(negedge clk);
    chk("rst_seq_wait_req", dm_req, 1'b0);
    chk("rst_seq_wait_busy", lsu_busy, 1'b1);
    resetn = 1'b0; req_vld = 1'b0;
    #1;
    chk("rst_async_req", dm_req, 1'b0);
    chk("rst_async_busy", lsu_busy, 1'b0);
    chk("rst_async_rf_we", rf_we, 1'b0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1; dm_rd_vld = 1'b1; dm_rd = 32'h5A5A_5A5A;
    @(negedge clk);
    @(posedge clk); #1 dm_rd_vld = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("post_rst_rf_we", rf_we, 1'b0);
      chk("post_rst_bus_err", bus_err, 1'b0);
      @(posedge clk); #1;
    end
    v = mk(0, 2, 0, 32'h0000_0600, 32'h0, 4, 1, 1, 32'h0BAD_F00D, 0, 0, 0, 0, 0, 0, 0);
    txn(model(v));

    // Randomized transactions against the reference model
    for (int i = 0; i < 150; i++) begin
      v.we   = 1'($urandom);
      v.sz   = 2'($urandom_range(0, 3));
      v.sg   = 1'($urandom);
      v.addr = $urandom;
      v.wd   = $urandom;
      v.wa   = 5'($urandom);
      v.a    = $urandom_range(0, 4);
      v.r    = $urandom_range(0, 4);
      v.rd   = $urandom;
      txn(model(v));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
